// File: rtl/fifo_write.sv
// fifo_write: serialises one parallel frame byte-by-byte into a TX FIFO,
// optionally followed by an XOR checksum, under the fs/fd level handshake.
module fifo_write #(
   parameter int BYTE_NUM = 12,
   parameter bit CHK_EN = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    err,
   input  logic [0:BYTE_NUM*8-1]   data,
   input  logic                    fifo_full,
   output logic [7:0]              fifo_txd,
   output logic                    fifo_txen,
   output logic [3:0]              state_fw,
   output logic                    abort,
   input  logic                    fs,
   output logic                    fd
);
   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] LOAD = 3'd1;
   localparam logic [2:0] WORK = 3'd2;
   localparam logic [2:0] CHK  = 3'd3;
   localparam logic [2:0] LAST = 3'd4;
   localparam logic [7:0] LAST_ADDR = 8'(BYTE_NUM - 1);
   logic [2:0] state;
   logic [7:0] addr;
   logic [7:0] chk;
   // Byte 0 of the latched frame always sits at the head; it shifts on each write.
   logic [0:BYTE_NUM*8-1] frame;
   always_comb begin
      fifo_txd = state == WORK ? frame[0:7] : state == CHK ? chk : 8'h00;
      fifo_txen = (state == WORK || state == CHK) && !fifo_full && !err;
      fd = state == LAST;
      state_fw = {1'b0, state};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         addr <= 8'd0;
         chk <= 8'h00;
         frame <= '0;
         abort <= 1'b0;
      end else begin
         case (state)
            IDLE: if (fs) state <= LOAD;
            LOAD: begin
               frame <= data;
               addr <= 8'd0;
               chk <= 8'h00;
               abort <= err;
               state <= err ? LAST : WORK;
            end
            WORK: begin
               if (err) begin
                  abort <= 1'b1;
                  state <= LAST;
               end else if (fifo_txen) begin
                  addr <= addr + 8'd1;
                  chk <= chk ^ frame[0:7];
                  frame <= frame << 8;
                  if (addr == LAST_ADDR) state <= CHK_EN ? CHK : LAST;
               end
            end
            CHK: begin
               if (err) begin
                  abort <= 1'b1;
                  state <= LAST;
               end else if (fifo_txen) begin
                  state <= LAST;
               end
            end
            LAST: if (!fs) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fifo_write.sv
// tb_fifo_write: randomized frames with back-pressure and aborts, checked by a
// queue scoreboard fed from the stimulus and drained by a write monitor.
module tb_fifo_write;
   localparam int N = 12;
   logic clk = 0, rst = 1, err = 0, fs = 0, fifo_full = 0;
   logic [0:N*8-1] data = '0;
   logic [7:0] fifo_txd;
   logic fifo_txen, abort, fd;
   logic [3:0] state_fw;
   logic fs1 = 0;
   logic [0:7] data1 = 8'hA5;
   logic [7:0] txd1;
   logic txen1, abort1, fd1;
   logic [3:0] st1;
   int cyc = 0, passed = 0, total = 0;
   int wr_cnt = 0, first_cyc = 0, last_cyc = 0, w1 = 0;
   bit mon_en = 0;
   byte unsigned exp_q[$];

   fifo_write #(.BYTE_NUM(N), .CHK_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .err(err), .data(data), .fifo_full(fifo_full),
      .fifo_txd(fifo_txd), .fifo_txen(fifo_txen), .state_fw(state_fw),
      .abort(abort), .fs(fs), .fd(fd));
   fifo_write #(.BYTE_NUM(1), .CHK_EN(1'b0)) dut1 (
      .clk(clk), .rst(rst), .err(1'b0), .data(data1), .fifo_full(1'b0),
      .fifo_txd(txd1), .fifo_txen(txen1), .state_fw(st1),
      .abort(abort1), .fs(fs1), .fd(fd1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (mon_en && fifo_txen) begin
         if (wr_cnt == 0) first_cyc = cyc;
         last_cyc = cyc;
         wr_cnt++;
         if (exp_q.size() == 0) begin
            total++;
            $display("FAIL extra_write: got write of %0h expected none (cycle %0d)", fifo_txd, cyc);
         end else check("txd", fifo_txd, exp_q.pop_front());
      end
      if (mon_en && txen1) begin
         w1++;
         check("txd1", txd1, 8'hA5);
      end
   end

   // full_pct < 0 selects the fixed stall on WORK cycles 4..6
   task automatic run_frame(input int ab, input int full_pct, input bit seq);
      byte unsigned b[N];
      byte unsigned x = 0;
      bit err_done = 0;
      int t0, k = 0, n_exp;
      for (int i = 0; i < N; i++) begin
         b[i] = seq ? byte'(i + 1) : byte'($urandom);
         data[i*8 +: 8] = b[i];
         x ^= b[i];
      end
      n_exp = ab < 0 ? N + 1 : ab;
      for (int i = 0; i < n_exp; i++) exp_q.push_back(i < N ? b[i] : x);
      wr_cnt = 0;
      fs = 1;
      t0 = cyc;
      while (k < 400) begin
         tick();
         k++;
         if (fd) break;
         if (k == 2) data = {N{8'hFF}};
         fifo_full = full_pct < 0 ? (k >= 5 && k <= 7) : ($urandom_range(99) < full_pct);
         err = !err_done && ab >= 0 && (state_fw == 4'd2 || state_fw == 4'd3) && wr_cnt == ab;
         if (err) err_done = 1;
         if (full_pct < 0 && k >= 5 && k <= 7) begin
            #1;
            check("stall_txd", fifo_txd, b[3]);
            check("stall_txen", fifo_txen, 0);
         end
      end
      err = 0;
      fifo_full = 0;
      check("fd_rise", fd, 1);
      check("abort", abort, ab >= 0);
      check("all_written", exp_q.size(), 0);
      if (ab < 0 && full_pct == 0) begin
         check("first_lat", first_cyc - t0, 2);
         check("burst_len", last_cyc - first_cyc, N);
         check("fd_lat", cyc - last_cyc, 1);
      end
      repeat ($urandom_range(3)) begin
         tick();
         check("fd_hold", fd, 1);
      end
      fs = 0;
      tick();
      check("fd_drop", fd, 0);
      check("idle", state_fw, 0);
      check("abort_hold", abort, ab >= 0);
   endtask

   task automatic run_reset();
      int k = 0;
      for (int i = 0; i < N; i++) begin
         data[i*8 +: 8] = 8'(i + 1);
         exp_q.push_back(byte'(i + 1));
      end
      wr_cnt = 0;
      fs = 1;
      while (wr_cnt < 5 && k < 100) begin
         tick();
         k++;
      end
      check("pre_reset_writes", wr_cnt, 5);
      rst = 1;
      fifo_full = 1;
      fs = 0;
      exp_q.delete();
      tick();
      rst = 0;
      fifo_full = 0;
      check("rst_state", state_fw, 0);
      check("rst_txen", fifo_txen, 0);
      check("rst_fd", fd, 0);
      tick();
   endtask

   initial begin
      tick(2);
      check("reset_state", state_fw, 0);
      check("reset_txen", fifo_txen, 0);
      check("reset_txd", fifo_txd, 0);
      check("reset_fd", fd, 0);
      check("reset_abort", abort, 0);
      rst = 0;
      mon_en = 1;
      fs1 = 1;
      tick(10);
      check("one_write", w1, 1);
      check("fd1_hold", fd1, 1);
      fs1 = 0;
      tick();
      check("fd1_drop", fd1, 0);
      fs1 = 1;
      tick(4);
      check("second_write", w1, 2);
      fs1 = 0;
      run_frame(-1, 0, 1);
      run_frame(-1, -1, 1);
      run_frame(5, 0, 1);
      run_reset();
      run_frame(-1, 0, 1);
      repeat (20) run_frame($urandom_range(3) == 0 ? int'($urandom_range(N)) : -1, $urandom_range(50), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/fifo_write.md
Name: fifo_write

Overview:
- Transmit-side counterpart of the frame reader: takes one BYTE_NUM-byte frame presented in parallel and writes it byte-serially into a byte-wide TX FIFO.
- Optionally appends a trailing XOR checksum byte.
- Started and completed with the team's fs/fd level handshake.
- Stalls on FIFO full and aborts cleanly on err.

Parameters:
- BYTE_NUM, 12, number of payload bytes per frame (1..255).
- CHK_EN, 1, 1 = append XOR checksum byte after payload; 0 = payload only.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- err  input  1  abort request; aborts the transfer in progress.
- data  input  [0:BYTE_NUM*8-1]  frame; byte k = data[k*8 +: 8], byte 0 sent first.
- fifo_full  input  1  TX FIFO full flag.
- fifo_txd  output  8  byte to FIFO.
- fifo_txen  output  1  FIFO write enable; one byte written per cycle high.
- state_fw  output  4  current state, zero-extended, for debug.
- abort  output  1  registered; last frame was aborted by err.
- fs  input  1  frame start, level; held high by master until fd seen.
- fd  output  1  frame done, level.

Behaviour:
- States and encodings: IDLE=0, LOAD=1, WORK=2, CHK=3, LAST=4. Any other value goes to IDLE.
- Reset: rst sampled high forces the following at the next edge, regardless of current state:
  - state=IDLE, addr=0, chk=8'h00, frame latch=0, abort=0.
  - Outputs fifo_txen=0, fifo_txd=0, fd=0, state_fw=0.
- IDLE: fs=1 -> LOAD.
- LOAD, one cycle:
  - Latch data into an internal frame register.
  - addr=0, chk=8'h00, abort=0.
  - Then WORK.
  - data changes after this edge are ignored for the frame.
- WORK:
  - fifo_txd = frame byte[addr].
  - fifo_txen = !fifo_full && !err (combinational).
  - On each cycle with fifo_txen=1: addr<=addr+1, chk<=chk^byte.
  - On the accepted write with addr==BYTE_NUM-1: go to CHK if CHK_EN, else LAST.
- CHK:
  - fifo_txd = chk; fifo_txen = !fifo_full && !err.
  - Accepted write -> LAST.
- LAST:
  - fd=1.
  - Stay while fs=1; fs=0 -> IDLE.
  - fd drops in the same cycle IDLE is entered.
- fd is high only in LAST (fd = state==LAST).
- fifo_txd is 8'h00 in all states other than WORK and CHK.
- Throughput: with fifo_full=0, writes occur on consecutive cycles.
  - First write is in the cycle after LOAD, i.e. two cycles after fs is sampled in IDLE.
  - fd rises the cycle after the final write.
- Stall on full: while fifo_full=1, addr, chk and state hold. No byte is skipped or duplicated.
- err in LOAD, WORK or CHK:
  - No write in that cycle (txen gated).
  - Next state LAST; abort<=1.
  - abort holds until the next LOAD.
  - err in IDLE or LAST is ignored.
- fs dropping before LAST does not abort the transfer; the frame completes.
  - If fs is already 0 on entering LAST, LAST lasts one cycle with fd=1.
- fs still high in LAST: no restart. A new frame needs fs=0 (return to IDLE) and then fs=1.
- Widths:
  - addr is 8 bits.
  - chk is 8 bits, seed 8'h00, XOR of payload bytes only.
  - Comparison against BYTE_NUM-1 is at 8 bits.

Test Plan:
- Normal frame:
  - Stimulus: BYTE_NUM=12, CHK_EN=1, data bytes 0x01..0x0C, fifo_full=0, fs held high.
  - Response: fifo_txen high for 13 consecutive cycles carrying 01,02,...,0C, then 0x0C (the checksum); fd=1 the next cycle. Drop fs -> IDLE and fd=0 one cycle later.
- Back-pressure:
  - Stimulus: same frame; fifo_full=1 during the 4th–6th WORK cycles.
  - Response: fifo_txen=0 in those cycles, txd held at 0x04, exactly 13 writes, byte order intact, checksum 0x0C.
- Abort:
  - Stimulus: err=1 for one cycle while byte 0x06 is presented.
  - Response: 0x06 is not written and no further writes occur; LAST with fd=1 and abort=1. The next frame clears abort in LOAD.
- Latch:
  - Stimulus: change data to all 0xFF one cycle after LOAD.
  - Response: FIFO still receives 01..0C and checksum 0x0C.
- Reset mid-frame:
  - Stimulus: rst=1 for one cycle after 5 writes.
  - Response: next edge state_fw=0, fifo_txen=0, fd=0. A subsequent fs sends the full frame starting from 0x01.
- No checksum and fs hold:
  - Stimulus: CHK_EN=0, BYTE_NUM=1, data=0xA5, fs held high 10 cycles.
  - Response: a single write of 0xA5, then fd stays high and there is no second write until fs toggles low and back high.
